// File: rtl/ex_div_unit.sv
// Iterative 32-bit integer divider for the EX stage: radix-2 restoring, one bit per cycle,
// signed (truncating) or unsigned, returning either quotient or remainder.
module ex_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic        sel_rem,
    input  logic        flag_unsigned,
    input  logic [31:0] src_j,
    input  logic [31:0] src_k,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        stall_req
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [32:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic        sel_rem_q;
    logic        unsigned_q;
    logic        sign_j_q;
    logic        sign_k_q;

    logic        accept;
    logic [31:0] abs_j;
    logic [31:0] abs_k;
    logic [33:0] rem_shift;
    logic [33:0] diff;
    logic        step_ok;
    logic [32:0] rem_d;
    logic [31:0] quo_d;
    logic        neg_quo;
    logic        neg_rem;
    logic [31:0] quo_res;
    logic [31:0] rem_res;

    assign accept = start && !flush && ((state_q == IDLE) || (state_q == DONE));

    assign abs_j = (!flag_unsigned && src_j[31]) ? (32'd0 - src_j) : src_j;
    assign abs_k = (!flag_unsigned && src_k[31]) ? (32'd0 - src_k) : src_k;

    // quo_q starts as the dividend magnitude and shifts its bits into the remainder MSB first
    assign rem_shift = {rem_q, quo_q[31]};
    assign diff      = rem_shift - {2'b00, dvs_q};
    assign step_ok   = !diff[33];
    assign rem_d     = step_ok ? diff[32:0] : rem_shift[32:0];
    assign quo_d     = {quo_q[30:0], step_ok};

    // A zero divisor yields all-ones quotient regardless of signs; remainder keeps the dividend
    assign neg_quo = !unsigned_q && (sign_j_q ^ sign_k_q) && (dvs_q != 32'd0);
    assign neg_rem = !unsigned_q && sign_j_q;
    assign quo_res = neg_quo ? (32'd0 - quo_d) : quo_d;
    assign rem_res = neg_rem ? (32'd0 - rem_d[31:0]) : rem_d[31:0];

    assign stall_req = rst_n && ((state_q == CALC) ||
                                 (((state_q == IDLE) || (state_q == DONE)) && start && !flush));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            rem_q      <= 33'd0;
            quo_q      <= 32'd0;
            dvs_q      <= 32'd0;
            sel_rem_q  <= 1'b0;
            unsigned_q <= 1'b0;
            sign_j_q   <= 1'b0;
            sign_k_q   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= 32'd0;
        end else if (flush) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        state_q    <= CALC;
                        busy       <= 1'b1;
                        cnt_q      <= 6'd0;
                        rem_q      <= 33'd0;
                        quo_q      <= abs_j;
                        dvs_q      <= abs_k;
                        sel_rem_q  <= sel_rem;
                        unsigned_q <= flag_unsigned;
                        sign_j_q   <= !flag_unsigned && src_j[31];
                        sign_k_q   <= !flag_unsigned && src_k[31];
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == 6'd31) begin
                        state_q <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        result  <= sel_rem_q ? rem_res : quo_res;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div_unit.sv
// Bench for ex_div_unit: a latency-counting reference model built on plain integer division,
// checked every cycle, plus directed literal cases and randomized divides.
module tb_ex_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        sel_rem = 1'b0;
    logic        flag_unsigned = 1'b0;
    logic [31:0] src_j = 32'd0;
    logic [31:0] src_k = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        stall_req;

    int n_checks = 0;
    int n_fail   = 0;

    ex_div_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .flush         (flush),
        .sel_rem       (sel_rem),
        .flag_unsigned (flag_unsigned),
        .src_j         (src_j),
        .src_k         (src_k),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .stall_req     (stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of a divide, straight from the arithmetic rules
    function automatic logic [31:0] ref_div(input logic [31:0] j, input logic [31:0] k,
                                            input logic u, input logic sel);
        logic [31:0] q;
        logic [31:0] r;
        if (k == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = j;
        end else if (u) begin
            q = j / k;
            r = j % k;
        end else if (j == 32'h8000_0000 && k == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $signed(j) / $signed(k);
            r = $signed(j) % $signed(k);
        end
        return sel ? r : q;
    endfunction

    // Timing model: an accepted divide completes 32 edges later, result appears with done
    logic        m_started = 1'b0;
    logic        m_active  = 1'b0;
    int          m_left    = 0;
    logic        m_done    = 1'b0;
    logic [31:0] m_result  = 32'd0;
    logic [31:0] m_pending = 32'd0;

    always @(posedge clk) begin
        m_started = 1'b1;
        if (!rst_n) begin
            m_active = 1'b0;
            m_left   = 0;
            m_done   = 1'b0;
            m_result = 32'd0;
        end else if (flush) begin
            m_active = 1'b0;
            m_done   = 1'b0;
        end else if (!m_active && start) begin
            m_active  = 1'b1;
            m_left    = 32;
            m_done    = 1'b0;
            m_pending = ref_div(src_j, src_k, flag_unsigned, sel_rem);
        end else if (m_active) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_active = 1'b0;
                m_done   = 1'b1;
                m_result = m_pending;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("busy", 32'(busy), 32'(m_active));
            chk("done", 32'(done), 32'(m_done));
            chk("result", result, m_result);
            chk("stall_req", 32'(stall_req),
                32'(rst_n && (m_active || (start && !flush))));
        end
    end

    // Ends #1 after the edge that enters DONE; b2b issues start right away in that DONE cycle
    task automatic issue(input logic [31:0] j, input logic [31:0] k, input logic u,
                         input logic sel, input logic b2b);
        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        src_j = j;
        src_k = k;
        flag_unsigned = u;
        sel_rem = sel;
        @(posedge clk);
        #1;
        start = 1'b0;
        src_j = $urandom;
        src_k = $urandom;
        flag_unsigned = 1'($urandom_range(0, 1));
        sel_rem = 1'($urandom_range(0, 1));
        repeat (32) @(posedge clk);
        #1;
    endtask

    task automatic run_chk(input string name, input logic [31:0] j, input logic [31:0] k,
                           input logic u, input logic sel, input logic b2b,
                           input logic [31:0] exp);
        issue(j, k, u, sel, b2b);
        chk({name, "_done_t33"}, 32'(done), 32'd1);
        chk(name, result, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] j;
        logic [31:0] k;
        logic [31:0] held;
        logic        u;
        logic        sel;
        logic        b2b;

        // pin the model with hand-computed values
        chk("model_u_q", ref_div(32'd100, 32'd7, 1'b1, 1'b0), 32'h0000_000E);
        chk("model_s_r", ref_div(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1), 32'hFFFF_FFFF);
        chk("model_ovf", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0), 32'h8000_0000);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", result, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        run_chk("u_quo",  32'd100, 32'd7, 1'b1, 1'b0, 1'b0, 32'h0000_000E);
        run_chk("u_rem",  32'd100, 32'd7, 1'b1, 1'b1, 1'b0, 32'h0000_0002);
        run_chk("s_quo1", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFD);
        run_chk("s_rem1", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        run_chk("s_quo2", 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFD);
        run_chk("s_rem2", 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 32'h0000_0001);
        run_chk("dz_s_q", 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        run_chk("dz_s_r", 32'h1234_5678, 32'd0, 1'b0, 1'b1, 1'b0, 32'h1234_5678);
        run_chk("dz_u_q", 32'h1234_5678, 32'd0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
        run_chk("dz_u_r", 32'h1234_5678, 32'd0, 1'b1, 1'b1, 1'b0, 32'h1234_5678);
        run_chk("ovf_q",  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h8000_0000);
        run_chk("ovf_r",  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h0000_0000);
        // back-to-back: start in the DONE cycle
        run_chk("b2b",    32'd1000, 32'd33, 1'b1, 1'b0, 1'b1, 32'd30);

        // start during CALC is ignored
        @(posedge clk);
        #1;
        start = 1'b1; src_j = 32'd500; src_k = 32'd9; flag_unsigned = 1'b1; sel_rem = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; src_j = 32'd77; src_k = 32'd2; sel_rem = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (26) @(posedge clk);
        #1;
        chk("calc_start_done", 32'(done), 32'd1);
        chk("calc_start_res", result, 32'd55);

        // flush at T+10
        held = result;
        issue_flush: begin
            @(posedge clk);
            #1;
            start = 1'b1; src_j = 32'd12345; src_k = 32'd10;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (9) @(posedge clk);
            #1;
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
            chk("flush_busy", 32'(busy), 32'd0);
            chk("flush_stall", 32'(stall_req), 32'd0);
            repeat (30) @(posedge clk);
            #1;
            chk("flush_result_held", result, held);
        end

        // start together with flush stays idle
        start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        chk("start_flush_busy", 32'(busy), 32'd0);

        // reset mid-CALC at T+20
        @(posedge clk);
        #1;
        start = 1'b1; src_j = 32'd999; src_k = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_chk("after_rst", 32'd999, 32'd3, 1'b1, 1'b0, 1'b0, 32'd333);

        // randomized divides, some back-to-back, checked by the model each cycle
        for (int i = 0; i < 40; i++) begin
            j = $urandom;
            case ($urandom_range(0, 5))
                0: k = 32'd0;
                1: k = 32'hFFFF_FFFF;
                2: k = 32'($urandom_range(1, 15));
                3: k = 32'd0 - 32'($urandom_range(1, 15));
                default: k = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) j = 32'h8000_0000;
            u = 1'($urandom_range(0, 1));
            sel = 1'($urandom_range(0, 1));
            b2b = ($urandom_range(0, 2) == 0);
            issue(j, k, u, sel, b2b);
        end

        repeat (4) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_div_unit.md
EX_DIV_UNIT -- requirements
Module: ex_div_unit

Interface
REQ-001 The block SHALL use reset rst_n, synchronous, active-low, and clock clk.
REQ-002 The block SHALL have these ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request a divide; operands valid this cycle (EX stage, driven from the ID/EX register outputs)
- flush  in  1  pipeline flush; abort any divide
- sel_rem  in  1  0 = return quotient, 1 = return remainder
- flag_unsigned  in  1  1 = unsigned divide, 0 = signed (two's complement)
- src_j  in  32  dividend (forwarded rj)
- src_k  in  32  divisor (forwarded rk)
- busy  out  1  divide in progress
- done  out  1  one-cycle pulse; result valid
- result  out  32  quotient or remainder, per sel_rem latched at start
- stall_req  out  1  hold IF/ID and ID/EX (wen low) until done

Function
REQ-003 The block SHALL implement FSM states IDLE, CALC and DONE.
REQ-004 Transitions SHALL be:
- IDLE->CALC on start & !flush
- CALC->DONE when the iteration counter reaches 31
- DONE->CALC on start & !flush
- DONE->IDLE otherwise
REQ-005 On accepting start, the block SHALL latch sel_rem, flag_unsigned, the operand signs, |src_j| and |src_k| (raw values if unsigned), and clear the 6-bit counter and the 33-bit partial remainder.
REQ-006 CALC SHALL perform one radix-2 restoring step per cycle, MSB first, for exactly 32 cycles.
REQ-007 Latency: start sampled at edge T -> done=1 and result valid during cycle T+33 (32 CALC cycles, then DONE).
REQ-008 busy SHALL be 1 in CALC only; done SHALL be 1 in DONE only.
REQ-009 stall_req SHALL be combinational: (IDLE & start & !flush) | CALC | (DONE & start & !flush).
REQ-010 Signed sign rules:
- quotient is negated iff the operand signs differ
- remainder takes the sign of the dividend (truncating division)
REQ-011 Divisor zero SHALL take the normal 32-cycle path, giving quotient 0xFFFFFFFF and remainder = src_j, for both signed and unsigned.
REQ-012 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0x00000000.
REQ-013 result SHALL be registered, updated only on entry to DONE, and held until the next DONE.
REQ-014 start while in CALC SHALL be ignored, with no re-latch of operands.
REQ-015 flush in any state SHALL force IDLE at the next edge, suppress done, and leave result unchanged; flush takes priority over a simultaneous start.
REQ-016 The counter SHALL NOT wrap; it is cleared on every accepted start.

Reset
REQ-017 While rst_n=0 at an edge, the block SHALL go to state IDLE with counter=0, busy=0, done=0, result=0x00000000 and all latched operand registers=0.
REQ-018 stall_req SHALL be forced to 0 while rst_n=0.
REQ-019 Reset asserted mid-CALC SHALL abort the divide with no done pulse; the first start after release behaves as from IDLE.

Verification
REQ-020 Unsigned: start at T with src_j=100, src_k=7, sel_rem=0 -> done at T+33, result=0x0000000E; repeat with sel_rem=1 -> result=0x00000002.
REQ-021 Signed: src_j=0xFFFFFFF9 (-7), src_k=2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; src_j=7, src_k=0xFFFFFFFE -> quotient 0xFFFFFFFD, remainder 0x00000001.
REQ-022 Corner values: src_k=0, src_j=0x12345678 (signed and unsigned) -> quotient 0xFFFFFFFF, remainder 0x12345678; signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-023 Flush: flush at T+10 of a divide -> busy=0 and stall_req=0 at T+11, no done pulse, result keeps its prior value; start with flush in the same cycle -> stays IDLE.
REQ-024 Back-to-back and reset: start asserted in the DONE cycle with new operands -> second done exactly 33 cycles later with the correct result; start during CALC -> first result unaffected; rst_n low at T+20 -> all outputs 0, no done.
